// File: rtl/muldiv_unit.sv
// Multicycle multiply/divide unit with HI/LO result registers.
// One shift-add or restoring-division step per cycle on magnitudes, then a sign-fix cycle.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StRun, StFix, StDone} state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               op_q, op_d;
  logic               neg_q, neg_d;
  logic               neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               done_q, done_d;
  logic               div_zero_q, div_zero_d;

  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     mul_sum, div_shl, div_diff;
  logic [2*WIDTH-1:0] mul_acc, div_acc;

  always_comb begin
    abs_a = (signed_op && a[WIDTH-1]) ? -a : a;
    abs_b = (signed_op && b[WIDTH-1]) ? -b : b;

    // acc = {partial product, remaining multiplier bits}; shifted right each step
    mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opnd_q : '0)};
    mul_acc = {mul_sum, acc_q[WIDTH-1:1]};

    // acc = {partial remainder, dividend bits / quotient bits}; shifted left each step
    div_shl  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff = div_shl - {1'b0, opnd_q};
    div_acc  = div_diff[WIDTH] ? {div_shl[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                               : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    opnd_d     = opnd_q;
    op_d       = op_q;
    neg_d      = neg_q;
    neg_rem_d  = neg_rem_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    div_zero_d = div_zero_q;

    unique case (state_q)
      StIdle: begin
        // The done cycle still counts as busy, so starts are ignored there
        if (start && !done_q) begin
          op_d       = op;
          neg_d      = signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
          neg_rem_d  = signed_op & a[WIDTH-1];
          cnt_d      = '0;
          div_zero_d = 1'b0;
          if (op) begin
            acc_d  = {{WIDTH{1'b0}}, abs_a};
            opnd_d = abs_b;
          end else begin
            acc_d  = {{WIDTH{1'b0}}, abs_b};
            opnd_d = abs_a;
          end
          state_d = (op && (b == '0)) ? StDone : StRun;
        end
      end
      StRun: begin
        cnt_d = cnt_q + CntW'(1);
        acc_d = op_q ? div_acc : mul_acc;
        if (cnt_q == CntW'(WIDTH - 1)) state_d = StFix;
      end
      StFix: begin
        if (op_q) begin
          acc_d = {(neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH]),
                   (neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0])};
        end else if (neg_q) begin
          acc_d = -acc_q;
        end
        state_d = StDone;
      end
      StDone: begin
        done_d  = 1'b1;
        state_d = StIdle;
        // opnd_q holds |b|, which is zero exactly when b was zero
        if (op_q && (opnd_q == '0)) begin
          div_zero_d = 1'b1;
        end else begin
          hi_d = acc_q[2*WIDTH-1:WIDTH];
          lo_d = acc_q[WIDTH-1:0];
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      acc_q      <= '0;
      opnd_q     <= '0;
      op_q       <= 1'b0;
      neg_q      <= 1'b0;
      neg_rem_q  <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      opnd_q     <= opnd_d;
      op_q       <= op_d;
      neg_q      <= neg_d;
      neg_rem_q  <= neg_rem_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign busy     = (state_q != StIdle) || done_q;
  assign done     = done_q;
  assign div_zero = div_zero_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Multicycle multiply/divide unit with HI/LO result registers for the MIPS multicycle datapath. It serves the mult, multu, div and divu instructions: the control unit pulses `start`, waits on `busy`/`done`, then routes `hi`/`lo` into the register-write mux. Width is parametrised, and signed/unsigned operation is selected per instruction. It uses iterative shift-add and restoring-division datapaths, one bit per cycle.

## Interface
- `WIDTH`, default 32: operand width; `hi`/`lo` are each WIDTH bits. Legal range is WIDTH ≥ 4.
- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `reset` input, 1 bit: one clock; reset is asynchronous and active-low.
- `start` input, 1 bit: request a new operation; sampled only in IDLE.
- `op` input, 1 bit: 0 = multiply, 1 = divide; sampled with `start`.
- `signed_op` input, 1 bit: 1 = two's-complement (mult/div), 0 = unsigned (multu/divu); sampled with `start`.
- `a` input, WIDTH bits: multiplicand or dividend (register A value); sampled with `start`.
- `b` input, WIDTH bits: multiplier or divisor (register B value); sampled with `start`.
- `busy` output, 1 bit: high from the cycle after `start` is accepted until `done`, inclusive of FIX.
- `done` output, 1 bit: single-cycle completion pulse.
- `div_zero` output, 1 bit: the last divide had b == 0.
- `hi` output, WIDTH bits: multiply gives the upper product half; divide gives the remainder.
- `lo` output, WIDTH bits: multiply gives the lower product half; divide gives the quotient.

## Operation
- Reset (reset = 0, any time, including mid-operation):
  - State goes to IDLE.
  - `busy`, `done` and `div_zero` go to 0.
  - `hi` and `lo` go to 0.
  - Internal counter and accumulators are cleared.
- States:
  - IDLE → RUN on start = 1.
  - IDLE → DONE on start = 1 with op = 1 and b == 0.
  - RUN → FIX when the iteration counter reaches WIDTH−1.
  - FIX → DONE.
  - DONE → IDLE unconditionally.
- Accept (IDLE with start = 1):
  - Latch `op` and `signed_op`.
  - If signed_op = 1, latch |a| and |b| and record the result signs: product sign = a[MSB]^b[MSB]; quotient sign = a[MSB]^b[MSB]; remainder sign = a[MSB].
  - Clear the counter and accumulators.
  - `div_zero` is cleared on every accepted start.
- Divide by zero: skip RUN/FIX. In DONE, div_zero = 1 and `hi`/`lo` hold their previous values.
- RUN, multiply: one shift-add step per cycle over a 2·WIDTH-bit accumulator, for WIDTH cycles.
- RUN, divide: one restoring step per cycle (shift remainder left, trial subtract divisor, set quotient bit), for WIDTH cycles.
- FIX (signed_op = 1):
  - Negate the product if the product sign is 1.
  - Negate the quotient if the quotient sign is 1.
  - Negate the remainder if the remainder sign is 1.
  - Division truncates toward zero.
- FIX (signed_op = 0): pass the magnitude results through unchanged. FIX always costs one cycle, so latency is uniform.
- DONE: load `hi`/`lo` from the result and pulse `done` for one cycle.
- `hi`/`lo` change only in DONE and otherwise hold indefinitely.
- Signed overflow, most-negative ÷ −1: lo = 2^(WIDTH−1) (wraps), hi = 0. No flag is raised.
- Absolute value of the most-negative operand is handled as an unsigned WIDTH-bit magnitude 2^(WIDTH−1). No extra bit is needed.
- `start` while `busy` (RUN/FIX/DONE) is ignored. It is not queued, and the in-flight operands are unaffected.
- Operand inputs may change freely after the accept edge.

## Timing
- Accept edge = E0.
- Normal op: RUN occupies E1..EWIDTH, FIX ends at EWIDTH+1, and DONE is registered at EWIDTH+2. `done` = 1 and the new `hi`/`lo` are visible during the cycle after EWIDTH+2. Total latency is WIDTH+2 cycles (34 for WIDTH = 32).
- Divide by zero: `done` and `div_zero` are visible in the cycle after E1, so latency is 1 cycle.
- `busy` = 1 from E0 through the `done` cycle. `busy` = 0 in IDLE.
- A new start is accepted in the cycle after the `done` cycle at the earliest.
- Reset deassertion: the first start can be accepted at the next rising edge.

## Test plan
- Signed multiply: WIDTH = 32, op = 0, signed_op = 1, a = 7, b = −3 → hi = 0xFFFFFFFF, lo = 0xFFFFFFEB; `done` pulses exactly 34 cycles after accept; `busy` is high throughout.
- Multiply extremes: a = b = 0x80000000. Signed → hi = 0x40000000, lo = 0. Unsigned → hi = 0x40000000, lo = 0. Then a = b = 0xFFFFFFFF unsigned → hi = 0xFFFFFFFE, lo = 0x00000001.
- Signed divide: a = −7, b = 2 → lo = 0xFFFFFFFD, hi = 0xFFFFFFFF. Unsigned divide: a = 100, b = 7 → lo = 14, hi = 2. Signed overflow: a = 0x80000000, b = −1 → lo = 0x80000000, hi = 0.
- Divide by zero: preload hi/lo with a multiply 5×6 (lo = 30), then divide a = 9, b = 0 → `done` after 1 cycle, div_zero = 1, hi = 0, lo = 30. The next accepted start clears div_zero.
- Start while busy: pulse start with new operands at cycles 5 and 20 of a running multiply 3×4 → result lo = 12, hi = 0, and exactly one `done` pulse.
- Reset mid-op: assert reset at cycle 10 of a divide → `busy`, `done`, `hi` and `lo` are all 0 immediately (asynchronous, before the next edge). After release, a fresh 6×7 gives lo = 42 with 34-cycle latency.
